// File: rtl/rgb2gray_pad_if.sv
// Pixel-in / padded-byte-out port bundle for rgb2gray_pad.
// The master drives RGB pixels and start; the slave (the converter) drives the line-buffer side.
interface rgb2gray_pad_if;
  logic       start_i;
  logic [7:0] r_i;
  logic [7:0] g_i;
  logic [7:0] b_i;
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic [7:0] data_o;
  logic       shift_en_o;
  logic       frame_done_o;
  logic       busy_o;

  modport master (
    output start_i, r_i, g_i, b_i, pix_valid_i,
    input  pix_ready_o, data_o, shift_en_o, frame_done_o, busy_o
  );

  modport slave (
    input  start_i, r_i, g_i, b_i, pix_valid_i,
    output pix_ready_o, data_o, shift_en_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/rgb2gray_pad.sv
// RGB-to-luma converter that wraps each frame in a one-pixel zero border for the Sobel line buffer.
// Build option: define GRAY_ROUND_EN to round luma to nearest instead of truncating.
module rgb2gray_pad #(
  parameter int WIDTH = 354,
  parameter int HIGH  = 425
) (
  input  logic          clk,
  input  logic          reset_n,
  rgb2gray_pad_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HIGH + 2);
  localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH + 1);
  localparam logic [CW-1:0] COL_PIX_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(HIGH - 1);
`ifdef GRAY_ROUND_EN
  localparam logic [16:0] GRAY_K = 17'd128;
`else
  localparam logic [16:0] GRAY_K = 17'd0;
`endif

  typedef enum logic [2:0] {IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    data_q, data_d;
  logic          shift_en_q, shift_en_d;
  logic          frame_done_q, frame_done_d;
  logic          pix_hs;

  // Coefficients sum to 256, so the 17-bit sum shifted by 8 always fits in a byte.
  function automatic logic [7:0] gray_f(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    logic [16:0] acc;
    acc = 17'd77 * {9'd0, r} + 17'd150 * {9'd0, g} + 17'd29 * {9'd0, b} + GRAY_K;
    return 8'(acc >> 8);
  endfunction

  assign pix_hs = bus.pix_valid_i && (state_q == PIX);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    data_d       = data_q;
    shift_en_d   = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = TOP;
          col_d   = '0;
          row_d   = '0;
        end
      end
      TOP: begin
        shift_en_d = 1'b1;
        data_d     = 8'd0;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = LEFT;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      LEFT: begin
        shift_en_d = 1'b1;
        data_d     = 8'd0;
        col_d      = '0;
        state_d    = PIX;
      end
      PIX: begin
        // A stalled cycle emits nothing and leaves data_o at its last value.
        if (pix_hs) begin
          shift_en_d = 1'b1;
          data_d     = gray_f(bus.r_i, bus.g_i, bus.b_i);
          if (col_q == COL_PIX_LAST) begin
            state_d = RIGHT;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      RIGHT: begin
        shift_en_d = 1'b1;
        data_d     = 8'd0;
        col_d      = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = BOTTOM;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = LEFT;
        end
      end
      BOTTOM: begin
        shift_en_d = 1'b1;
        data_d     = 8'd0;
        if (col_q == COL_LAST) begin
          col_d        = '0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      data_q       <= 8'd0;
      shift_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      data_q       <= data_d;
      shift_en_q   <= shift_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.shift_en_o   = shift_en_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.pix_ready_o  = (state_q == PIX);
  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: doc/rgb2gray_pad.md
# rgb2gray_pad

Streaming front end of the edge-detection pipeline. Accepts one frame of RGB pixels in raster order and converts each to 8-bit luma with integer coefficients. Wraps the frame in a one-pixel zero border and emits the padded stream, (WIDTH+2)×(HIGH+2) bytes, one per strobe. Drives `data_i`/`shift_en` of the 3-row line buffer that feeds the Sobel convolution.

## Interface
- `WIDTH`, 354, active pixels per row (≥1)
- `HIGH`, 425, active rows per frame (≥1)

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  frame start request, sampled only in IDLE
- `r_i`  in  8  red component
- `g_i`  in  8  green component
- `b_i`  in  8  blue component
- `pix_valid_i`  in  1  RGB inputs hold a valid pixel
- `pix_ready_o`  out  1  block accepts a pixel this cycle
- `data_o`  out  8  padded gray byte, to line buffer `data_i`
- `shift_en_o`  out  1  `data_o` valid this cycle, to line buffer `shift_en`
- `frame_done_o`  out  1  one-cycle pulse with the last padded byte
- `busy_o`  out  1  frame in progress (state ≠ IDLE)

## Operation
- States: IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM. Counters: `col` 0..WIDTH+1, `row` 0..HIGH+1.
- IDLE: `start_i`=1 → TOP, with `col`=`row`=0.
- TOP: emit 0 each cycle for WIDTH+2 cycles, then → LEFT.
- LEFT: emit 0 for one cycle → PIX.
- PIX: `pix_ready_o`=1. Each handshake (`pix_valid_i`&`pix_ready_o`) emits gray(r,g,b). After WIDTH handshakes → RIGHT.
- RIGHT: emit 0 for one cycle. If fewer than HIGH rows are done → LEFT; otherwise → BOTTOM.
- BOTTOM: emit 0 for WIDTH+2 cycles. `frame_done_o` is asserted with the final byte → IDLE.
- Gray: Y = (77·R + 150·G + 29·B + K) >> 8, computed in 17 bits. K is set under Configuration. The coefficients sum to 256, so Y ≤ 255 and there is no saturation.
- Padding states never consume input. PIX never emits padding.
- Input stall in PIX (`pix_valid_i`=0) → `shift_en_o`=0 that cycle; `data_o` holds its last value.
- There is no downstream backpressure: every strobe must be taken.
- `start_i` while `busy_o`=1 is ignored; no queuing.
- Total strobes per frame is exactly (WIDTH+2)·(HIGH+2).

## Timing
- Reset: state IDLE, counters 0. `data_o`=0, `shift_en_o`=0, `frame_done_o`=0, `busy_o`=0, `pix_ready_o`=0.
- Reset mid-frame discards the frame immediately (asynchronous). The next `start_i` begins a full new frame.
- `data_o`, `shift_en_o` and `frame_done_o` are registered.
- `pix_ready_o` and `busy_o` decode the state register combinationally.
- `start_i` sampled at edge k → state TOP after edge k. The first zero appears on `data_o`/`shift_en_o` after edge k+1.
- Pixel handshake at edge n → its gray byte on `data_o` with `shift_en_o`=1 after edge n. Conversion latency is 1 cycle.
- Padding cycles strobe back-to-back. With continuous `pix_valid_i`, a frame takes exactly (WIDTH+2)·(HIGH+2) strobe cycles, with no gaps.
- IDLE returns after the last byte. The earliest next `start_i` is sampled one cycle after `frame_done_o`.

## Configuration
- `GRAY_ROUND_EN` defined: K=128 (round to nearest).
- `GRAY_ROUND_EN` undefined: K=0 (truncate).
- Everything else is identical in both builds.

## Test plan
- Reset: assert `reset_n`=0 mid-stream → all outputs 0 and state IDLE. No strobes until `start_i`.
- WIDTH=4, HIGH=3, R=G=B=200, `pix_valid_i`=1 → exactly 30 strobes in 30 consecutive cycles:
  - 6×0
  - then 3×{0,200,200,200,200,0}
  - then 6×0
  - `frame_done_o` on strobe 30.
- Coefficients, single pixels:
  - (255,0,0) → 77 with `GRAY_ROUND_EN`, 76 without.
  - (0,255,0) → 149 in both builds.
  - (0,0,255) → 29 with, 28 without.
- Stall: drop `pix_valid_i` for 5 cycles after the 2nd pixel of row 2:
  - `shift_en_o`=0 for those 5 cycles, no extra zeros.
  - Still 30 strobes, in the same byte order as the unstalled frame.
- Pulse `start_i` during TOP and during PIX → ignored. A single frame of 30 strobes; `busy_o` stays 1 until the final byte.
- Reset after strobe 12, then `start_i` → one fresh 30-strobe frame beginning with the 6 top-border zeros.
